// File: rtl/iso14443_3a_pkg.sv
// iso14443_3a_pkg: shared ISO/IEC 14443-3A frame-delay-time constants and FSM states.
package iso14443_3a_pkg;
  localparam int FDT_BIT_TICKS = 128;
  localparam int FDT_OFFSET_0 = 20;
  localparam int FDT_OFFSET_1 = 84;
  typedef enum logic [1:0] {IDLE, DELAY, GRID} fdt_state_t;
endpackage

// File: rtl/fdt_grid_if.sv
// fdt_grid_if: pause/rx inputs and tx trigger outputs of the frame-delay-time timer.
interface fdt_grid_if #(
  parameter int N_WIDTH = 8,
  parameter int SLOT_WIDTH = 4
);
  logic pause_n_synchronised;
  logic last_rx_bit;
  logic [N_WIDTH-1:0] n_min;
  logic tx_req;
  logic trigger;
  logic timeout;
  logic [SLOT_WIDTH-1:0] fdt_slot;
  logic busy;
  modport master (
    output pause_n_synchronised, last_rx_bit, n_min, tx_req,
    input trigger, timeout, fdt_slot, busy
  );
  modport slave (
    input pause_n_synchronised, last_rx_bit, n_min, tx_req,
    output trigger, timeout, fdt_slot, busy
  );
endinterface

// File: rtl/fdt_grid_counter.sv
// fdt_grid_counter: 7-bit bit-grid phase counter plus saturating slot index.
module fdt_grid_counter
  import iso14443_3a_pkg::*;
#(
  parameter int MAX_SLOTS = 16,
  parameter int SLOT_WIDTH = $clog2(MAX_SLOTS)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic start,
  input  logic run,
  output logic grid_point,
  output logic [SLOT_WIDTH-1:0] k
);
  localparam logic [SLOT_WIDTH-1:0] K_LAST = SLOT_WIDTH'(MAX_SLOTS - 1);
  logic [6:0] phase;
  // k names the slot of the next grid point; grid entry happens at T0, so the next one is slot 1
  assign grid_point = run && phase == 7'(FDT_BIT_TICKS - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
      k <= '0;
    end else if (clr) begin
      phase <= '0;
      k <= '0;
    end else if (start) begin
      phase <= '0;
      k <= SLOT_WIDTH'(MAX_SLOTS > 1 ? 1 : 0);
    end else if (run) begin
      phase <= phase + 7'd1;
      if (grid_point && k != K_LAST) k <= k + SLOT_WIDTH'(1);
    end
  end
endmodule

// File: rtl/fdt_grid.sv
// fdt_grid: runtime-n ISO 14443-3A FDT timer triggering tx on the first ready bit-grid slot.
// FDT_TIMEOUT_EN: give up with a timeout pulse after slot MAX_SLOTS-1; otherwise keep offering slots.
module fdt_grid
  import iso14443_3a_pkg::*;
#(
  parameter int TIMING_ADJUST = 4,
  parameter int N_WIDTH = 8,
  parameter int MAX_SLOTS = 16,
  parameter int SLOT_WIDTH = $clog2(MAX_SLOTS)
) (
  input logic clk,
  input logic rst,
  fdt_grid_if.slave bus
);
  localparam int CW = N_WIDTH + 8;
  fdt_state_t state, state_n;
  logic prev, rise, fall, grid_point, at_point, clr, start, trig, trig_n;
  logic [CW-1:0] cnt, cnt_n, t0;
  logic [N_WIDTH-1:0] n_lat, n_n;
  logic [SLOT_WIDTH-1:0] slot_q, slot_n, slot, k;
`ifdef FDT_TIMEOUT_EN
  logic to_q, to_n, last;
  assign last = slot == SLOT_WIDTH'(MAX_SLOTS - 1);
`endif
  assign rise = bus.pause_n_synchronised & ~prev;
  assign fall = ~bus.pause_n_synchronised & prev;
  // last_rx_bit is read live so the offset reflects the bit that actually ended the frame
  assign t0 = CW'(n_lat) * CW'(FDT_BIT_TICKS)
            + (bus.last_rx_bit ? CW'(FDT_OFFSET_1) : CW'(FDT_OFFSET_0))
            - CW'(TIMING_ADJUST);
  assign slot = state == GRID ? k : '0;
  assign at_point = state == DELAY ? cnt == t0 - CW'(1) : state == GRID && grid_point;
  fdt_grid_counter #(.MAX_SLOTS(MAX_SLOTS), .SLOT_WIDTH(SLOT_WIDTH)) u_counter (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .start(start),
    .run(state == GRID),
    .grid_point(grid_point),
    .k(k)
  );
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    n_n = n_lat;
    trig_n = 1'b0;
    slot_n = slot_q;
    clr = 1'b0;
    start = 1'b0;
`ifdef FDT_TIMEOUT_EN
    to_n = 1'b0;
`endif
    if (rise) begin
      state_n = DELAY;
      cnt_n = '0;
      n_n = bus.n_min;
      clr = 1'b1;
    end else if (fall && state != IDLE) begin
      state_n = IDLE;
    end else if (state != IDLE) begin
      cnt_n = state == DELAY ? cnt + CW'(1) : cnt;
      if (at_point && bus.tx_req) begin
        trig_n = 1'b1;
        slot_n = slot;
        state_n = IDLE;
      end
`ifdef FDT_TIMEOUT_EN
      else if (at_point && last) begin
        to_n = 1'b1;
        state_n = IDLE;
      end
`endif
      else if (at_point && state == DELAY) begin
        state_n = GRID;
        start = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      prev <= 1'b1;
      cnt <= '0;
      n_lat <= '0;
      trig <= 1'b0;
      slot_q <= '0;
`ifdef FDT_TIMEOUT_EN
      to_q <= 1'b0;
`endif
    end else begin
      state <= state_n;
      prev <= bus.pause_n_synchronised;
      cnt <= cnt_n;
      n_lat <= n_n;
      trig <= trig_n;
      slot_q <= slot_n;
`ifdef FDT_TIMEOUT_EN
      to_q <= to_n;
`endif
    end
  end
  assign bus.trigger = trig;
  assign bus.fdt_slot = slot_q;
  assign bus.busy = state != IDLE;
`ifdef FDT_TIMEOUT_EN
  assign bus.timeout = to_q;
`else
  assign bus.timeout = 1'b0;
`endif
endmodule
